// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared encodings for the immediate generator stage
package imm_gen_pkg;

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate decode; U/J formats gated by IMM_GEN_UJ_EN
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt
);

   logic [31:0] raw;
   logic [2:0]  funct3;

   assign funct3 = instr[14:12];

   // Every format is first built as a correctly signed 32-bit value, then widened.
   always_comb begin
      raw = '0;
      fmt = FMT_NONE;
      case (instr[6:0])
         OP_IMM: begin
            fmt = FMT_I;
            if (funct3 == 3'b001 || funct3 == 3'b101)
               raw = (XLEN == 32) ? {27'b0, instr[24:20]} : {26'b0, instr[25:20]};
            else
               raw = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LOAD, OP_JALR: begin
            fmt = FMT_I;
            raw = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            fmt = FMT_S;
            raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            fmt = FMT_B;
            raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
`ifdef IMM_GEN_UJ_EN
         OP_LUI, OP_AUIPC: begin
            fmt = FMT_U;
            raw = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            fmt = FMT_J;
            raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
`endif
         default: begin
            raw = '0;
            fmt = FMT_NONE;
         end
      endcase
   end

`ifndef IMM_GEN_UJ_EN
   logic unused_rs1;
   assign unused_rs1 = ^instr[19:15];
`endif

   assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with 2-entry skid buffer; IMM_GEN_UJ_EN enables U/J
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [31:0]     instr_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      fmt_o
);

   state_t          state, state_nxt;
   logic [XLEN-1:0] dec_imm, out_imm, skid_imm;
   logic [2:0]      dec_fmt, out_fmt, skid_fmt;
   logic            push, pop;
   logic            load_out, load_skid, skid_to_out;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr (instr_i),
      .imm   (dec_imm),
      .fmt   (dec_fmt)
   );

   assign valid_o = (state != ST_EMPTY);
   assign ready_o = (state != ST_TWO);
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state <= ST_EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      if (flush_i) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  state_nxt = ST_ONE;
                  load_out  = 1'b1;
               end
            end
            ST_ONE: begin
               if (push && !pop) begin
                  state_nxt = ST_TWO;
                  load_skid = 1'b1;
               end else if (push && pop) begin
                  load_out = 1'b1;
               end else if (pop) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // No push is possible here since ready_o is low.
               if (pop) begin
                  state_nxt   = ST_ONE;
                  skid_to_out = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_imm  <= '0;
         out_fmt  <= FMT_NONE;
         skid_imm <= '0;
         skid_fmt <= FMT_NONE;
      end else begin
         if (load_out) begin
            out_imm <= dec_imm;
            out_fmt <= dec_fmt;
         end else if (skid_to_out) begin
            out_imm <= skid_imm;
            out_fmt <= skid_fmt;
         end
         if (load_skid) begin
            skid_imm <= dec_imm;
            skid_fmt <= dec_fmt;
         end
      end
   end

   assign imm_o = out_imm;
   assign fmt_o = out_fmt;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed bench for imm_gen_stage at XLEN 32 and 64; honours IMM_GEN_UJ_EN
module tb_imm_gen_stage;

`ifdef IMM_GEN_UJ_EN
   localparam bit UJ = 1'b1;
`else
   localparam bit UJ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b0;
   logic [31:0] instr_i = '0;
   logic        ready32, valid32, ready64, valid64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;

   int n_checks = 0;
   int n_fails  = 0;

   imm_gen_stage #(.XLEN(32)) u_dut32 (
      .clk_i (clk), .rst_i (rst_i), .flush_i (flush_i),
      .valid_i (valid_i), .ready_o (ready32), .instr_i (instr_i),
      .valid_o (valid32), .ready_i (ready_i), .imm_o (imm32), .fmt_o (fmt32)
   );

   imm_gen_stage #(.XLEN(64)) u_dut64 (
      .clk_i (clk), .rst_i (rst_i), .flush_i (flush_i),
      .valid_i (valid_i), .ready_o (ready64), .instr_i (instr_i),
      .valid_o (valid64), .ready_i (ready_i), .imm_o (imm64), .fmt_o (fmt64)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic exp_valid, input logic exp_ready);
      chk({tag, ".valid32"}, {63'b0, valid32}, {63'b0, exp_valid});
      chk({tag, ".ready32"}, {63'b0, ready32}, {63'b0, exp_ready});
      chk({tag, ".valid64"}, {63'b0, valid64}, {63'b0, exp_valid});
      chk({tag, ".ready64"}, {63'b0, ready64}, {63'b0, exp_ready});
   endtask

   task automatic chk_data(input string tag, input logic [2:0] exp_fmt,
                           input logic [31:0] exp32, input logic [63:0] exp64);
      chk({tag, ".imm32"}, {32'b0, imm32}, {32'b0, exp32});
      chk({tag, ".fmt32"}, {61'b0, fmt32}, {61'b0, exp_fmt});
      chk({tag, ".imm64"}, imm64, exp64);
      chk({tag, ".fmt64"}, {61'b0, fmt64}, {61'b0, exp_fmt});
   endtask

   task automatic push_one(input logic [31:0] ins);
      valid_i = 1'b1;
      instr_i = ins;
      tick();
   endtask

   initial begin
      #1;
      chk_flags("reset", 1'b0, 1'b1);
      chk_data("reset", 3'd0, 32'h0, 64'h0);
      tick();
      tick();
      rst_i   = 1'b0;
      ready_i = 1'b1;

      // Streaming at full rate, one format per cycle
      push_one(32'hFFF00093);
      chk_flags("addi", 1'b1, 1'b1);
      chk_data("addi", 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      push_one(32'hFE20AE23);
      chk_data("sw", 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
      push_one(32'hFE000CE3);
      chk_data("beq", 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);
      push_one(32'h4030D093);
      chk_data("srai", 3'd1, 32'h00000003, 64'h0000000000000003);
      push_one(32'h12345037);
      chk_data("lui", UJ ? 3'd4 : 3'd0, UJ ? 32'h12345000 : 32'h0,
               UJ ? 64'h0000000012345000 : 64'h0);
      push_one(32'h80000037);
      chk_data("lui_neg", UJ ? 3'd4 : 3'd0, UJ ? 32'h80000000 : 32'h0,
               UJ ? 64'hFFFFFFFF80000000 : 64'h0);
      push_one(32'hFFDFF06F);
      chk_data("jal", UJ ? 3'd5 : 3'd0, UJ ? 32'hFFFFFFFC : 32'h0,
               UJ ? 64'hFFFFFFFFFFFFFFFC : 64'h0);
      push_one(32'h00808067);
      chk_data("jalr", 3'd1, 32'h00000008, 64'h0000000000000008);
      push_one(32'h00000033);
      chk_data("rtype", 3'd0, 32'h0, 64'h0);
      valid_i = 1'b0;
      tick();
      chk_flags("drain", 1'b0, 1'b1);

      // Backpressure: two accepted, third held until the output drains
      ready_i = 1'b0;
      push_one(32'hFFF00093);
      chk_flags("bp1", 1'b1, 1'b1);
      push_one(32'hFE20AE23);
      chk_flags("bp2", 1'b1, 1'b0);
      chk_data("bp2", 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      push_one(32'hFE000CE3);
      chk_flags("bp3", 1'b1, 1'b0);
      chk_data("bp3", 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      ready_i = 1'b1;
      tick();
      chk_flags("pop1", 1'b1, 1'b1);
      chk_data("pop1", 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
      tick();
      chk_data("pop2", 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);
      valid_i = 1'b0;
      tick();
      chk_flags("pop3", 1'b0, 1'b1);

      // Flush while full, with a new instruction presented
      ready_i = 1'b0;
      push_one(32'hFFF00093);
      push_one(32'hFE20AE23);
      chk_flags("fill", 1'b1, 1'b0);
      flush_i = 1'b1;
      valid_i = 1'b1;
      instr_i = 32'h4030D093;
      tick();
      flush_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      chk_flags("flush", 1'b0, 1'b1);
      tick();
      chk_flags("post_flush", 1'b0, 1'b1);
      push_one(32'hFE000CE3);
      chk_flags("refill", 1'b1, 1'b1);
      chk_data("refill", 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);

      // Asynchronous reset between clock edges
      ready_i = 1'b0;
      push_one(32'hFFF00093);
      #2;
      rst_i = 1'b1;
      #1;
      chk_flags("async_rst", 1'b0, 1'b1);
      chk_data("async_rst", 3'd0, 32'h0, 64'h0);
      valid_i = 1'b0;
      tick();
      rst_i = 1'b0;
      tick();
      chk_flags("after_rst", 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
